// File: rtl/hovalaag_run_ctrl.sv
// Hovalaag run controller: program memory, two host-fed input FIFOs,
// two host-drained output FIFOs and the IDLE/RUN/DONE run sequencer
// that judges a CPU run as PASS, TIMEOUT, IN_UNDERFLOW or OUT_OVERFLOW.

// 16x12 FIFO with 4-bit index plus wrap bit; head is show-ahead, 0 when empty.
module hovalaag_run_ctrl_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [11:0] din,
    input  logic        pop,
    output logic [11:0] head,
    output logic        full,
    output logic        empty
);

    logic [11:0] mem [16];
    logic [4:0]  wr_ptr;
    logic [4:0]  rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    assign full    = (wr_ptr[4] != rd_ptr[4]) && (wr_ptr[3:0] == rd_ptr[3:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr[3:0]];

    // Storage write; full is judged on the pre-edge occupancy only.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[3:0]] <= din;
        end
    end

    // Pointer update; reset and flush both return the FIFO to empty.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 5'd1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 5'd1;
            end
        end
    end

endmodule

module hovalaag_run_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_we,
    input  logic [7:0]  prog_addr,
    input  logic [31:0] prog_data,
    input  logic        in1_wr,
    input  logic [11:0] in1_wdata,
    output logic        in1_full,
    input  logic        in2_wr,
    input  logic [11:0] in2_wdata,
    output logic        in2_full,
    input  logic        out1_rd,
    output logic [11:0] out1_rdata,
    output logic        out1_empty,
    input  logic        out2_rd,
    output logic [11:0] out2_rdata,
    output logic        out2_empty,
    input  logic        start,
    input  logic        flush,
    input  logic [7:0]  out1_target,
    input  logic [7:0]  out2_target,
    input  logic [15:0] cycle_limit,
    output logic        busy,
    output logic        done,
    output logic [2:0]  status,
    output logic [15:0] cycles,
    output logic        cpu_rst,
    output logic [31:0] cpu_instr,
    input  logic [7:0]  cpu_pc,
    output logic [11:0] cpu_in1,
    output logic [11:0] cpu_in2,
    input  logic        cpu_in1_adv,
    input  logic        cpu_in2_adv,
    input  logic [11:0] cpu_out,
    input  logic        cpu_out_valid,
    input  logic        cpu_out_select
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        STAT_NONE         = 3'd0,
        STAT_PASS         = 3'd1,
        STAT_TIMEOUT      = 3'd2,
        STAT_IN_UNDERFLOW = 3'd3,
        STAT_OUT_OVERFLOW = 3'd4
    } status_t;

    state_t      state;
    status_t     status_q;
    logic [15:0] cycles_q;
    logic [7:0]  out1_cnt;
    logic [7:0]  out2_cnt;
    logic [7:0]  out1_tgt;
    logic [7:0]  out2_tgt;
    logic [15:0] limit_q;

    logic [31:0] prog_mem [256];

    logic        run;
    logic        fifo_clr;
    logic        in1_empty;
    logic        in2_empty;
    logic        out1_full;
    logic        out2_full;
    logic        in1_pop;
    logic        in2_pop;
    logic        out1_push;
    logic        out2_push;
    logic        underflow;
    logic        overflow;
    logic        pass;
    logic        timeout;
    logic [7:0]  out1_cnt_nxt;
    logic [7:0]  out2_cnt_nxt;
    logic [15:0] cycles_nxt;

    assign run      = (state == ST_RUN);
    assign fifo_clr = flush && !run;

    assign busy    = run;
    assign done    = (state == ST_DONE);
    assign cpu_rst = !run;
    assign status  = status_q;
    assign cycles  = cycles_q;

    // Program memory is loaded only while the CPU is held in reset.
    always_ff @(posedge clk) begin
        if (prog_we && !run) begin
            prog_mem[prog_addr] <= prog_data;
        end
    end

    assign cpu_instr = prog_mem[cpu_pc];

    assign in1_pop   = run && cpu_in1_adv;
    assign in2_pop   = run && cpu_in2_adv;
    assign out1_push = run && cpu_out_valid && !cpu_out_select;
    assign out2_push = run && cpu_out_valid && cpu_out_select;

    hovalaag_run_ctrl_fifo u_in1 (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (in1_wr),
        .din   (in1_wdata),
        .pop   (in1_pop),
        .head  (cpu_in1),
        .full  (in1_full),
        .empty (in1_empty)
    );

    hovalaag_run_ctrl_fifo u_in2 (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (in2_wr),
        .din   (in2_wdata),
        .pop   (in2_pop),
        .head  (cpu_in2),
        .full  (in2_full),
        .empty (in2_empty)
    );

    hovalaag_run_ctrl_fifo u_out1 (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (out1_push),
        .din   (cpu_out),
        .pop   (out1_rd),
        .head  (out1_rdata),
        .full  (out1_full),
        .empty (out1_empty)
    );

    hovalaag_run_ctrl_fifo u_out2 (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (out2_push),
        .din   (cpu_out),
        .pop   (out2_rd),
        .head  (out2_rdata),
        .full  (out2_full),
        .empty (out2_empty)
    );

    // Terminating-event detection and post-update counter values for this RUN cycle.
    always_comb begin
        underflow    = run && ((cpu_in1_adv && in1_empty) || (cpu_in2_adv && in2_empty));
        overflow     = run && cpu_out_valid && (cpu_out_select ? out2_full : out1_full);
        out1_cnt_nxt = out1_cnt;
        out2_cnt_nxt = out2_cnt;
        if (out1_push && !out1_full && (out1_cnt != 8'hFF)) begin
            out1_cnt_nxt = out1_cnt + 8'd1;
        end
        if (out2_push && !out2_full && (out2_cnt != 8'hFF)) begin
            out2_cnt_nxt = out2_cnt + 8'd1;
        end
        cycles_nxt = (cycles_q == 16'hFFFF) ? cycles_q : cycles_q + 16'd1;
        pass       = (out1_cnt_nxt >= out1_tgt) && (out2_cnt_nxt >= out2_tgt);
        timeout    = (limit_q != 16'd0) && (cycles_nxt == limit_q);
    end

    // Run sequencer: start arms a run, the highest-priority terminating event ends it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            status_q <= STAT_NONE;
            cycles_q <= '0;
            out1_cnt <= '0;
            out2_cnt <= '0;
            out1_tgt <= '0;
            out2_tgt <= '0;
            limit_q  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        out1_tgt <= out1_target;
                        out2_tgt <= out2_target;
                        limit_q  <= cycle_limit;
                        cycles_q <= '0;
                        out1_cnt <= '0;
                        out2_cnt <= '0;
                        status_q <= STAT_NONE;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cycles_q <= cycles_nxt;
                    out1_cnt <= out1_cnt_nxt;
                    out2_cnt <= out2_cnt_nxt;
                    if (underflow) begin
                        status_q <= STAT_IN_UNDERFLOW;
                        state    <= ST_DONE;
                    end else if (overflow) begin
                        status_q <= STAT_OUT_OVERFLOW;
                        state    <= ST_DONE;
                    end else if (pass) begin
                        status_q <= STAT_PASS;
                        state    <= ST_DONE;
                    end else if (timeout) begin
                        status_q <= STAT_TIMEOUT;
                        state    <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
